// File: rtl/programador_pkg.sv
// Shared constants and FSM state type for the pill-dose scheduler.
package programador_pkg;
    localparam int N_COMP  = 4;
    localparam int T_MOTOR = 20000;
    localparam int INT_W   = 12;
    localparam int SEL_W   = 2;

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        DISPENSAR = 2'd1,
        ALERTA    = 2'd2
    } estado_t;
endpackage

// File: rtl/arbitro_rr.sv
// Combinational round-robin picker: first requester found searching upward
// from (last_served + 1) mod N, wrapping around.
module arbitro_rr #(
    parameter int N = programador_pkg::N_COMP
) (
    input  logic [N-1:0]                    req_i,
    input  logic [programador_pkg::SEL_W-1:0] last_served_i,
    output logic                            valid_o,
    output logic [programador_pkg::SEL_W-1:0] idx_o
);
    import programador_pkg::*;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = N; k >= 1; k--) begin
            if (req_i[(int'(last_served_i) + k) % N]) begin
                valid_o = 1'b1;
                idx_o   = SEL_W'((int'(last_served_i) + k) % N);
            end
        end
    end
endmodule

// File: rtl/programador_dosis.sv
// Pill-dose scheduler: per-compartment minute countdowns raise pending doses,
// which are dispensed one at a time in round-robin order and then announced.
module programador_dosis #(
    parameter int N_COMP  = programador_pkg::N_COMP,
    parameter int T_MOTOR = programador_pkg::T_MOTOR
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [23:0]                       tiempo,
    input  logic                              cfg_we,
    input  logic [1:0]                        cfg_sel,
    input  logic [programador_pkg::INT_W-1:0] cfg_intervalo,
    input  logic                              motor_done,
    input  logic                              boton_ack,
    output logic                              motor_req,
    output logic [1:0]                        motor_sel,
    output logic                              alarma,
    output logic [N_COMP-1:0]                 pendientes,
    output logic [N_COMP-1:0]                 perdidas,
    output logic                              error_motor,
    output logic [1:0]                        estado_dbg
);
    import programador_pkg::*;

    localparam int TW = $clog2(T_MOTOR + 1);

    estado_t          estado_q;
    logic [3:0]       min1_q;
    logic             tick;
    logic [INT_W-1:0] intervalo_q [N_COMP];
    logic [INT_W-1:0] intervalo_d [N_COMP];
    logic [INT_W-1:0] cnt_q [N_COMP];
    logic [INT_W-1:0] cnt_d [N_COMP];
    logic [N_COMP-1:0] pend_q, pend_d, perd_q, perd_d;
    logic [SEL_W-1:0] last_q, motor_sel_q, arb_idx;
    logic             arb_valid, grant;
    logic             motor_req_q, alarma_q, error_q;
    logic [TW-1:0]    tmr_q;
    logic             unused_tiempo;

    assign unused_tiempo = ^tiempo[23:4];
    assign tick  = (tiempo[3:0] != min1_q);
    assign grant = (estado_q == REPOSO) && arb_valid;

    arbitro_rr #(.N(N_COMP)) u_arb (
        .req_i         (pend_q),
        .last_served_i (last_q),
        .valid_o       (arb_valid),
        .idx_o         (arb_idx)
    );

    // A config write beats both the tick and the grant on its own compartment.
    always_comb begin
        pend_d = pend_q;
        perd_d = perd_q;
        for (int i = 0; i < N_COMP; i++) begin
            intervalo_d[i] = intervalo_q[i];
            cnt_d[i]       = cnt_q[i];
            if (grant && arb_idx == SEL_W'(i)) pend_d[i] = 1'b0;
            if (cfg_we && cfg_sel == SEL_W'(i)) begin
                intervalo_d[i] = cfg_intervalo;
                cnt_d[i]       = cfg_intervalo;
                pend_d[i]      = 1'b0;
                perd_d[i]      = 1'b0;
            end else if (tick && intervalo_q[i] != '0) begin
                if (cnt_q[i] == INT_W'(1)) begin
                    cnt_d[i]  = intervalo_q[i];
                    perd_d[i] = perd_q[i] | pend_d[i];
                    pend_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - INT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min1_q <= 4'h0;
            pend_q <= '0;
            perd_q <= '0;
            for (int i = 0; i < N_COMP; i++) begin
                intervalo_q[i] <= '0;
                cnt_q[i]       <= '0;
            end
        end else begin
            min1_q <= tiempo[3:0];
            pend_q <= pend_d;
            perd_q <= perd_d;
            for (int i = 0; i < N_COMP; i++) begin
                intervalo_q[i] <= intervalo_d[i];
                cnt_q[i]       <= cnt_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q    <= REPOSO;
            motor_req_q <= 1'b0;
            motor_sel_q <= '0;
            alarma_q    <= 1'b0;
            error_q     <= 1'b0;
            last_q      <= SEL_W'(N_COMP - 1);
            tmr_q       <= '0;
        end else begin
            case (estado_q)
                REPOSO: begin
                    if (grant) begin
                        motor_req_q <= 1'b1;
                        motor_sel_q <= arb_idx;
                        last_q      <= arb_idx;
                        tmr_q       <= '0;
                        estado_q    <= DISPENSAR;
                    end
                end
                DISPENSAR: begin
                    if (motor_done) begin
                        motor_req_q <= 1'b0;
                        alarma_q    <= 1'b1;
                        estado_q    <= ALERTA;
                    end else if (tmr_q == TW'(T_MOTOR - 1)) begin
                        motor_req_q <= 1'b0;
                        error_q     <= 1'b1;
                        estado_q    <= REPOSO;
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                ALERTA: begin
                    if (boton_ack) begin
                        alarma_q <= 1'b0;
                        estado_q <= REPOSO;
                    end
                end
                default: estado_q <= REPOSO;
            endcase
        end
    end

    assign motor_req   = motor_req_q;
    assign motor_sel   = motor_sel_q;
    assign alarma      = alarma_q;
    assign pendientes  = pend_q;
    assign perdidas    = perd_q;
    assign error_motor = error_q;
    assign estado_dbg  = estado_q;
endmodule

// File: doc/programador_dosis.md
PROGRAMADOR_DOSIS -- requirements
Module: programador_dosis

Interface
REQ-001 The block SHALL have parameter N_COMP, default 4, giving the number of pill compartments served.
REQ-002 The block SHALL have parameter T_MOTOR, default 20000, giving the motor-done timeout in clk cycles (2 s at 10 kHz).
REQ-003 The block SHALL have these ports:
- clk  in  1  10 kHz system clock; all state on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- tiempo  in  24  BCD time {dia2,dia1,hora2,hora1,min2,min1} from the time-keeping block.
- cfg_we  in  1  configuration write strobe, one cycle.
- cfg_sel  in  2  target compartment index.
- cfg_intervalo  in  12  dose interval in minutes, binary; 0 = compartment disabled.
- motor_done  in  1  dispenser motor finished (level, sampled).
- boton_ack  in  1  user acknowledge, synchronous, already debounced.
- motor_req  out  1  drive dispenser motor.
- motor_sel  out  2  compartment being dispensed.
- alarma  out  1  dose-ready buzzer/LED.
- pendientes  out  N_COMP  per-compartment dose due, not yet dispensed.
- perdidas  out  N_COMP  sticky missed-dose flags.
- error_motor  out  1  sticky motor timeout flag.

Function
REQ-004 The block SHALL derive a one-cycle minute tick when tiempo[3:0] differs from its value registered on the previous cycle; the registered copy resets to 4'h0.
REQ-005 Each compartment SHALL hold intervalo (12 b), a minute down-counter cnt (12 b) and a pend bit.
REQ-006 On cfg_we, compartment cfg_sel SHALL load intervalo = cfg_intervalo and cnt = cfg_intervalo, and clear its pend and perdidas bits, in the same cycle.
REQ-007 On a tick, each compartment with intervalo != 0 SHALL do: if cnt == 1, then cnt = intervalo and pend = 1; else cnt = cnt - 1.
REQ-008 If a compartment expires (REQ-007) while pend is already 1, its perdidas bit SHALL set; pend stays 1.
REQ-009 cfg_we coinciding with a tick on the same compartment SHALL take the config write; the tick is ignored for that compartment only.
REQ-010 The FSM SHALL have states REPOSO, DISPENSAR and ALERTA.
REQ-011 REPOSO: when any pend is 1, the block SHALL grant the round-robin winner, searching upward from (last_served+1) mod N_COMP; last_served resets to N_COMP-1.
- On grant, the block SHALL clear the winner's pend, latch motor_sel, update last_served, and move to DISPENSAR.
REQ-012 DISPENSAR: motor_req SHALL be 1.
- On motor_done = 1, the block SHALL go to ALERTA.
- If T_MOTOR cycles elapse without motor_done, the block SHALL set error_motor and return to REPOSO with no alarm.
REQ-013 ALERTA: alarma SHALL be 1 until boton_ack = 1, then the FSM SHALL return to REPOSO; the next grant occurs no earlier than the following cycle.
REQ-014 Ticks, expiries and config writes SHALL proceed in every FSM state; a config write to the compartment being served SHALL NOT abort DISPENSAR or ALERTA.
REQ-015 Grant latency SHALL be one cycle: pend set at edge k is granted at edge k+1 when the FSM is in REPOSO.
REQ-016 motor_req and alarma SHALL be registered, glitch-free, and never high together.

Reset
REQ-017 On rst = 1, the block SHALL immediately force the following, without waiting for clk:
- FSM = REPOSO; all intervalo, cnt and pend = 0.
- perdidas = 0 and error_motor = 0.
- motor_req = 0, motor_sel = 0, alarma = 0; timeout counter = 0.
REQ-018 Reset asserted mid-DISPENSAR SHALL drop motor_req at once; the interrupted dose is lost and not re-queued.

Structure
REQ-019 A shared package programador_pkg SHALL hold N_COMP, T_MOTOR, the interval width (12) and the FSM state enum.
REQ-020 Round-robin selection SHALL be a sub-module arbitro_rr (inputs: request vector, last_served; outputs: valid, index), purely combinational.

Verification
REQ-021 Config compartment 0 with interval 2, then apply 2 minute ticks -> pendientes[0] rises on the 2nd tick, motor_req = 1 and motor_sel = 0 one cycle later.
REQ-022 Set pend on compartments 1 and 3 in the same cycle with last_served = 1 -> compartment 3 is served first, then compartment 1, each after motor_done and boton_ack.
REQ-023 Hold motor_done low for T_MOTOR cycles -> error_motor = 1 and FSM returns to REPOSO; alarma never asserts.
REQ-024 Interval 1, with the FSM held in ALERTA (no boton_ack) for 2 ticks -> perdidas[0] = 1 and pendientes[0] = 1.
REQ-025 Assert rst during DISPENSAR -> motor_req = 0 before the next clk edge, and all outputs read zero.
REQ-026 Apply cfg_we to compartment 2 on the same cycle as a tick -> cnt equals the new interval, with no decrement.
